// File: rtl/ram_controller_mister_ddr_if.sv
// ram_controller_mister_ddr_if: four memory client ports plus the MiSTer DDRAM bridge signals
interface ram_controller_mister_ddr_if;
  logic [13:0] mcr_addr;
  logic [48:0] mcr_data_in;
  logic [48:0] mcr_data_out;
  logic        mcr_ready;
  logic        mcr_write;
  logic        mcr_done;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_in;
  logic [31:0] sdram_data_out;
  logic        sdram_req;
  logic        sdram_ready;
  logic        sdram_write;
  logic        sdram_done;
  logic [14:0] vram_cpu_addr;
  logic [31:0] vram_cpu_data_in;
  logic [31:0] vram_cpu_data_out;
  logic        vram_cpu_req;
  logic        vram_cpu_ready;
  logic        vram_cpu_write;
  logic        vram_cpu_done;
  logic [14:0] vram_vga_addr;
  logic [31:0] vram_vga_data_out;
  logic        vram_vga_req;
  logic        vram_vga_ready;
  logic        DDRAM_CLK;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  modport slave (
    input  mcr_addr, mcr_data_in, mcr_write,
    output mcr_data_out, mcr_ready, mcr_done,
    input  sdram_addr, sdram_data_in, sdram_req, sdram_write,
    output sdram_data_out, sdram_ready, sdram_done,
    input  vram_cpu_addr, vram_cpu_data_in, vram_cpu_req, vram_cpu_write,
    output vram_cpu_data_out, vram_cpu_ready, vram_cpu_done,
    input  vram_vga_addr, vram_vga_req,
    output vram_vga_data_out, vram_vga_ready,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
  modport master (
    output mcr_addr, mcr_data_in, mcr_write,
    input  mcr_data_out, mcr_ready, mcr_done,
    output sdram_addr, sdram_data_in, sdram_req, sdram_write,
    input  sdram_data_out, sdram_ready, sdram_done,
    output vram_cpu_addr, vram_cpu_data_in, vram_cpu_req, vram_cpu_write,
    input  vram_cpu_data_out, vram_cpu_ready, vram_cpu_done,
    output vram_vga_addr, vram_vga_req,
    input  vram_vga_data_out, vram_vga_ready,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
endinterface

// File: rtl/ram_controller_mister_ddr.sv
// ram_controller_mister_ddr: arbitrates MCR, main memory and two VRAM ports onto one DDRAM bridge
module ram_controller_mister_ddr #(
  parameter logic [28:0] DDR_BASE = 29'h0600_0000
) (
  input logic clk,
  input logic reset,
  ram_controller_mister_ddr_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RDWAIT = 2'd3;
  localparam logic [2:0] C_SD = 3'd0, C_CPU = 3'd1, C_VGA = 3'd2, C_MCRW = 3'd3, C_MCRF = 3'd4;
  localparam logic [28:0] VRAM_BASE = DDR_BASE + 29'h40_0000;
  localparam logic [28:0] MCR_BASE = DDR_BASE + 29'h48_0000;
  logic [1:0] state;
  logic [2:0] sel, grant;
  logic [13:0] mcr_tag, mcr_lat;
  logic mcr_valid;
  logic vga_pend, mcrw_pend, mcrf_pend, cpu_pend, sd_pend, any_pend, g_wr;
  logic [28:0] g_addr;
  logic [63:0] g_din;
  logic [7:0] g_be;
  assign bus.DDRAM_CLK = clk;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.mcr_ready = mcr_valid && bus.mcr_addr == mcr_tag;
  // a client still holding its acknowledge is not eligible again
  always_comb begin
    vga_pend = bus.vram_vga_req && !bus.vram_vga_ready;
    mcrw_pend = bus.mcr_write && !bus.mcr_done;
    mcrf_pend = !bus.mcr_ready;
    cpu_pend = (bus.vram_cpu_req || bus.vram_cpu_write) && !bus.vram_cpu_ready && !bus.vram_cpu_done;
    sd_pend = (bus.sdram_req || bus.sdram_write) && !bus.sdram_ready && !bus.sdram_done;
    any_pend = vga_pend || mcrw_pend || mcrf_pend || cpu_pend || sd_pend;
    grant = vga_pend ? C_VGA : mcrw_pend ? C_MCRW : mcrf_pend ? C_MCRF : cpu_pend ? C_CPU : C_SD;
    g_wr = grant == C_MCRW || (grant == C_CPU && bus.vram_cpu_write) || (grant == C_SD && bus.sdram_write);
    g_addr = grant == C_SD ? DDR_BASE + {7'd0, bus.sdram_addr} :
             grant == C_CPU ? VRAM_BASE + {14'd0, bus.vram_cpu_addr} :
             grant == C_VGA ? VRAM_BASE + {14'd0, bus.vram_vga_addr} :
             MCR_BASE + {15'd0, bus.mcr_addr};
    g_din = grant == C_MCRW ? {15'd0, bus.mcr_data_in} :
            {32'd0, grant == C_CPU ? bus.vram_cpu_data_in : bus.sdram_data_in};
    g_be = g_wr && grant != C_MCRW ? 8'h0F : 8'hFF;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel <= C_SD;
      mcr_tag <= '0;
      mcr_lat <= '0;
      mcr_valid <= 1'b0;
      bus.mcr_data_out <= '0;
      bus.mcr_done <= 1'b0;
      bus.sdram_data_out <= '0;
      bus.sdram_ready <= 1'b0;
      bus.sdram_done <= 1'b0;
      bus.vram_cpu_data_out <= '0;
      bus.vram_cpu_ready <= 1'b0;
      bus.vram_cpu_done <= 1'b0;
      bus.vram_vga_data_out <= '0;
      bus.vram_vga_ready <= 1'b0;
      bus.DDRAM_ADDR <= '0;
      bus.DDRAM_DIN <= '0;
      bus.DDRAM_BE <= '0;
      bus.DDRAM_RD <= 1'b0;
      bus.DDRAM_WE <= 1'b0;
    end else begin
      if (bus.mcr_done && !bus.mcr_write) bus.mcr_done <= 1'b0;
      if (bus.sdram_ready && !bus.sdram_req) bus.sdram_ready <= 1'b0;
      if (bus.sdram_done && !bus.sdram_write) bus.sdram_done <= 1'b0;
      if (bus.vram_cpu_ready && !bus.vram_cpu_req) bus.vram_cpu_ready <= 1'b0;
      if (bus.vram_cpu_done && !bus.vram_cpu_write) bus.vram_cpu_done <= 1'b0;
      if (bus.vram_vga_ready && !bus.vram_vga_req) bus.vram_vga_ready <= 1'b0;
      case (state)
        IDLE: if (any_pend) begin
          sel <= grant;
          mcr_lat <= bus.mcr_addr;
          bus.DDRAM_ADDR <= g_addr;
          bus.DDRAM_DIN <= g_din;
          bus.DDRAM_BE <= g_be;
          state <= g_wr ? WR : RD;
        end
        // the command strobe rises one cycle after the grant and holds through BUSY
        WR: if (!bus.DDRAM_WE) bus.DDRAM_WE <= 1'b1;
        else if (!bus.DDRAM_BUSY) begin
          bus.DDRAM_WE <= 1'b0;
          state <= IDLE;
          if (sel == C_SD) bus.sdram_done <= 1'b1;
          if (sel == C_CPU) bus.vram_cpu_done <= 1'b1;
          if (sel == C_MCRW) bus.mcr_done <= 1'b1;
          if (sel == C_MCRW && mcr_valid && mcr_lat == mcr_tag) bus.mcr_data_out <= bus.DDRAM_DIN[48:0];
        end
        RD: if (!bus.DDRAM_RD) bus.DDRAM_RD <= 1'b1;
        else if (!bus.DDRAM_BUSY) begin
          bus.DDRAM_RD <= 1'b0;
          state <= RDWAIT;
        end
        default: if (bus.DDRAM_DOUT_READY) begin
          state <= IDLE;
          if (sel == C_SD) begin
            bus.sdram_data_out <= bus.DDRAM_DOUT[31:0];
            bus.sdram_ready <= 1'b1;
          end
          if (sel == C_CPU) begin
            bus.vram_cpu_data_out <= bus.DDRAM_DOUT[31:0];
            bus.vram_cpu_ready <= 1'b1;
          end
          if (sel == C_VGA) begin
            bus.vram_vga_data_out <= bus.DDRAM_DOUT[31:0];
            bus.vram_vga_ready <= 1'b1;
          end
          if (sel == C_MCRF) begin
            bus.mcr_data_out <= bus.DDRAM_DOUT[48:0];
            mcr_tag <= mcr_lat;
            mcr_valid <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_controller_mister_ddr.sv
// tb_ram_controller_mister_ddr: directed checks of the DDR arbiter against a small bridge model
module tb_ram_controller_mister_ddr;
  localparam logic [28:0] BASE = 29'h0600_0000;
  localparam logic [28:0] VB = BASE + 29'h40_0000;
  localparam logic [28:0] MB = BASE + 29'h48_0000;
  localparam logic [48:0] MCRV = 49'o111100001111;
  logic clk = 1'b0, reset = 1'b1;
  ram_controller_mister_ddr_if bus();
  ram_controller_mister_ddr dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [63:0] mem [2048];
  logic [28:0] raddr, last_waddr;
  logic [63:0] last_din;
  logic [7:0] last_be;
  int rdly = 0, nwr = 0;
  bit stray = 1'b0;
  logic [28:0] rd_log [$];
  logic [31:0] q;
  int n, k, w0;
  logic [28:0] a0;
  logic [63:0] d0;
  logic [7:0] b0;
  bit stable;
  logic [21:0] sa [4] = '{22'd0, 22'd1, 22'd2, 22'd4};
  logic [31:0] sd [4] = '{32'd0, 32'o10101111, 32'o20202222, 32'o30303333};
  logic [14:0] va [3] = '{15'd100, 15'd102, 15'd104};
  logic [31:0] vd [3] = '{32'o12345670, 32'o22222222, 32'o33333333};
  function automatic logic [10:0] idx(input logic [28:0] a);
    return {a[22:19], a[6:0]};
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din, input logic [7:0] be);
    for (int i = 0; i < 8; i++) if (be[i]) old[8*i +: 8] = din[8*i +: 8];
    return old;
  endfunction
  initial for (int i = 0; i < 2048; i++) mem[i] = 64'd0;
  // bridge model: read data returns a few cycles after the command is accepted
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rdly <= 0;
      bus.DDRAM_DOUT_READY <= 1'b0;
      bus.DDRAM_DOUT <= 64'd0;
    end else begin
      bus.DDRAM_DOUT_READY <= rdly == 1 || stray;
      if (rdly == 1) bus.DDRAM_DOUT <= mem[idx(raddr)];
      if (rdly > 0) rdly <= rdly - 1;
      if (bus.DDRAM_RD && !bus.DDRAM_BUSY) begin
        raddr <= bus.DDRAM_ADDR;
        rdly <= 3;
        rd_log.push_back(bus.DDRAM_ADDR);
      end
      if (bus.DDRAM_WE && !bus.DDRAM_BUSY) begin
        mem[idx(bus.DDRAM_ADDR)] <= merge(mem[idx(bus.DDRAM_ADDR)], bus.DDRAM_DIN, bus.DDRAM_BE);
        last_waddr <= bus.DDRAM_ADDR;
        last_din <= bus.DDRAM_DIN;
        last_be <= bus.DDRAM_BE;
        nwr <= nwr + 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int p, input bit wr, input bit on, input logic [21:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.sdram_addr = a;
      bus.sdram_data_in = d;
      bus.sdram_write = on && wr;
      bus.sdram_req = on && !wr;
    end else if (p == 1) begin
      bus.vram_cpu_addr = a[14:0];
      bus.vram_cpu_data_in = d;
      bus.vram_cpu_write = on && wr;
      bus.vram_cpu_req = on && !wr;
    end else begin
      bus.vram_vga_addr = a[14:0];
      bus.vram_vga_req = on;
    end
  endtask
  function automatic logic ack(input int p, input bit wr);
    return p == 0 ? (wr ? bus.sdram_done : bus.sdram_ready) :
           p == 1 ? (wr ? bus.vram_cpu_done : bus.vram_cpu_ready) : bus.vram_vga_ready;
  endfunction
  task automatic xfer(input int p, input bit wr, input logic [21:0] a, input logic [31:0] d,
                      output logic [31:0] rq, output int rn);
    drive(p, wr, 1'b1, a, d);
    rn = 0;
    @(negedge clk);
    while (!ack(p, wr) && rn < 100) begin
      @(negedge clk);
      rn++;
    end
    chk("ack", ack(p, wr), 1'b1);
    rq = p == 0 ? bus.sdram_data_out : p == 1 ? bus.vram_cpu_data_out : bus.vram_vga_data_out;
    drive(p, wr, 1'b0, a, d);
    @(negedge clk);
    chk("ack_clr", ack(p, wr), 1'b0);
  endtask
  task automatic wait_mcr();
    n = 0;
    while (!bus.mcr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mcr_ready", bus.mcr_ready, 1'b1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.mcr_addr = '0; bus.mcr_data_in = '0; bus.mcr_write = 1'b0;
    drive(0, 1'b0, 1'b0, 22'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 22'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 22'd0, 32'd0);
    bus.DDRAM_BUSY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", {bus.DDRAM_WE, bus.DDRAM_RD, bus.DDRAM_BE}, 10'd0);
    chk("rst_addr", bus.DDRAM_ADDR, 29'd0);
    chk("rst_din", bus.DDRAM_DIN, 64'd0);
    chk("rst_acks", {bus.mcr_ready, bus.mcr_done, bus.sdram_ready, bus.sdram_done,
                     bus.vram_cpu_ready, bus.vram_cpu_done, bus.vram_vga_ready}, 7'd0);
    chk("rst_data", {bus.sdram_data_out, bus.vram_cpu_data_out}, 64'd0);
    chk("rst_mcr_data", bus.mcr_data_out, 49'd0);
    chk("burstcnt", bus.DDRAM_BURSTCNT, 8'd1);
    reset = 1'b0;
    wait_mcr();
    chk("first_fetch_cnt", rd_log.size(), 1);
    chk("first_fetch_addr", rd_log[0], MB);
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b1, {7'd0, va[i]}, vd[i], q, n);
      if (i == 0) chk("wr_latency", n, 2);
      chk("cpu_wr_addr", last_waddr, VB + {14'd0, va[i]});
      chk("cpu_wr_be", last_be, 8'h0F);
      chk("cpu_wr_din", last_din, {32'd0, vd[i]});
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b0, {7'd0, va[i]}, 32'd0, q, n);
      if (i == 0) chk("rd_latency", n, 6);
      chk("cpu_rd_data", q, vd[i]);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(2, 1'b0, {7'd0, va[i]}, 32'd0, q, n);
      chk("vga_rd_data", q, vd[i]);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, sa[i], sd[i], q, n);
      chk("sd_wr_addr", last_waddr, BASE + {7'd0, sa[i]});
    end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, sa[i], 32'd0, q, n);
      chk("sd_rd_data", q, sd[i]);
    end
    bus.mcr_data_in = MCRV;
    bus.mcr_write = 1'b1;
    n = 0;
    while (!bus.mcr_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mcr_done", bus.mcr_done, 1'b1);
    chk("mcr_wr_addr", last_waddr, MB);
    chk("mcr_wr_be", last_be, 8'hFF);
    chk("mcr_wr_din", last_din, {15'd0, MCRV});
    bus.mcr_write = 1'b0;
    @(negedge clk);
    chk("mcr_done_clr", bus.mcr_done, 1'b0);
    chk("mcr_wt_ready", bus.mcr_ready, 1'b1);
    chk("mcr_wt_data", bus.mcr_data_out, MCRV);
    bus.mcr_addr = 14'd1;
    #1 chk("mcr_miss1", bus.mcr_ready, 1'b0);
    wait_mcr();
    chk("mcr_fetch1", bus.mcr_data_out, 49'd0);
    bus.mcr_addr = 14'd0;
    #1 chk("mcr_miss0", bus.mcr_ready, 1'b0);
    wait_mcr();
    chk("mcr_fetch0", bus.mcr_data_out, MCRV);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_acks", {bus.vram_vga_ready, bus.vram_cpu_ready, bus.sdram_ready}, 3'd0);
    chk("stray_mcr", {bus.mcr_ready, bus.mcr_data_out}, {1'b1, MCRV});
    bus.DDRAM_BUSY = 1'b1;
    k = rd_log.size();
    w0 = nwr;
    drive(0, 1'b1, 1'b1, 22'd7, 32'h0BAD_CAFE);
    repeat (2) @(negedge clk);
    drive(2, 1'b0, 1'b1, 22'd102, 32'd0);
    drive(1, 1'b0, 1'b1, 22'd100, 32'd0);
    a0 = bus.DDRAM_ADDR; d0 = bus.DDRAM_DIN; b0 = bus.DDRAM_BE;
    stable = bus.DDRAM_WE;
    repeat (5) begin
      @(negedge clk);
      stable &= bus.DDRAM_WE && bus.DDRAM_ADDR == a0 && bus.DDRAM_DIN == d0 && bus.DDRAM_BE == b0;
    end
    chk("busy_hold", stable, 1'b1);
    chk("busy_cmd", {a0, b0, d0}, {BASE + 29'd7, 8'h0F, 32'd0, 32'h0BAD_CAFE});
    chk("busy_no_wr", nwr, w0);
    bus.DDRAM_BUSY = 1'b0;
    n = 0;
    while (!(bus.sdram_done && bus.vram_vga_ready && bus.vram_cpu_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("prio_acks", {bus.sdram_done, bus.vram_vga_ready, bus.vram_cpu_ready}, 3'b111);
    chk("prio_first", rd_log[k], VB + 29'd102);
    chk("prio_second", rd_log[k+1], VB + 29'd100);
    chk("prio_data", {bus.vram_vga_data_out, bus.vram_cpu_data_out}, {32'o22222222, 32'o12345670});
    drive(0, 1'b1, 1'b0, 22'd7, 32'd0);
    drive(1, 1'b0, 1'b0, 22'd100, 32'd0);
    drive(2, 1'b0, 1'b0, 22'd102, 32'd0);
    @(negedge clk);
    chk("prio_clr", {bus.sdram_done, bus.vram_vga_ready, bus.vram_cpu_ready}, 3'b000);
    repeat (10) @(negedge clk);
    chk("prio_rd_count", rd_log.size(), k + 2);
    chk("prio_wr_count", nwr, w0 + 1);
    bus.DDRAM_BUSY = 1'b1;
    drive(1, 1'b1, 1'b1, 22'd110, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("mid_we", bus.DDRAM_WE, 1'b1);
    w0 = nwr;
    reset = 1'b1;
    #1 chk("mid_rst_cmd", {bus.DDRAM_WE, bus.DDRAM_RD}, 2'b00);
    drive(1, 1'b1, 1'b0, 22'd110, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.DDRAM_BUSY = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", bus.vram_cpu_done, 1'b0);
    chk("mid_no_wr", nwr, w0);
    chk("mid_refetch", {bus.mcr_ready, bus.mcr_data_out}, {1'b1, MCRV});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_controller_mister_ddr.md
# ram_controller_mister_ddr

Single-clock memory arbiter that maps four client ports onto the MiSTer DDR3 Avalon-style port. The four clients are microcode RAM (MCR, 49-bit), main memory (“sdram”, 32-bit), CPU-side video RAM and VGA-side video RAM. It sits between the Lisp-machine core/video logic and the HPS DDRAM bridge. Each client word occupies one 64-bit DDR word.

## Interface
- DDR_BASE, 29'h0600_0000: 64-bit-word base address of the controller's DDR window.
- clk  in  1  sole clock; all client and DDRAM signals are synchronous to it.
- reset  in  1  asynchronous, active-high.
- mcr_addr  in  14  microcode word address.
- mcr_data_in  in  49  microcode write data.
- mcr_data_out  out  49  microcode read data.
- mcr_ready  out  1  mcr_data_out is valid for the current mcr_addr.
- mcr_write  in  1  write request, level.
- mcr_done  out  1  write acknowledge.
- sdram_addr  in  22  main-memory word address.
- sdram_data_in  in  32  write data.
- sdram_data_out  out  32  read data.
- sdram_req  in  1  read request, level.
- sdram_ready  out  1  read acknowledge.
- sdram_write  in  1  write request, level.
- sdram_done  out  1  write acknowledge.
- vram_cpu_addr  in  15  CPU-side VRAM address.
- vram_cpu_data_in  in  32  write data.
- vram_cpu_data_out  out  32  read data.
- vram_cpu_req  in  1  read request.
- vram_cpu_ready  out  1  read acknowledge.
- vram_cpu_write  in  1  write request.
- vram_cpu_done  out  1  write acknowledge.
- vram_vga_addr  in  15  VGA-side VRAM address.
- vram_vga_data_out  out  32  read data.
- vram_vga_req  in  1  read request.
- vram_vga_ready  out  1  read acknowledge.
- DDRAM_CLK  out  1  equals clk.
- DDRAM_BUSY  in  1  bridge stall.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  64-bit word address.
- DDRAM_DOUT  in  64  read data from the bridge.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data to the bridge.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.

## Operation
- Address map, DDRAM_ADDR =
  - sdram: DDR_BASE + sdram_addr.
  - VRAM (both vram ports): DDR_BASE + 29'h40_0000 + vram addr. Both VRAM ports share this storage.
  - MCR: DDR_BASE + 29'h48_0000 + mcr_addr.
- 32-bit writes: DIN = {32'b0, data}, BE = 8'h0F. Reads return DOUT[31:0].
- MCR writes: DIN = {15'b0, data}, BE = 8'hFF. Reads return DOUT[48:0].
- Handshake for sdram and vram_cpu:
  - The client holds req/write plus addr/data until ready/done is 1.
  - ready/done stays 1, with read data stable, until the client drops the request; it clears the cycle after.
  - A new request is accepted only after the acknowledge has cleared.
  - If write and req are both high, the write is serviced.
- vram_vga: same handshake as above, read only.
- MCR reads are implicit:
  - The block keeps a one-entry cache (fetched address plus valid bit).
  - mcr_ready = valid && mcr_addr == fetched address, combinational.
  - On a mismatch, a read of mcr_addr is issued.
  - An MCR write to the fetched address updates the cache (write-through).
- Arbitration happens in IDLE only. Fixed priority: vram_vga > mcr_write > mcr fetch > vram_cpu > sdram. Exactly one DDR transaction is outstanding at a time.
- State machine:
  - IDLE: grant a pending request and latch addr/data/BE.
  - WR: WE=1 until BUSY=0 at an edge; then set done and go to IDLE.
  - RD: RD=1 until BUSY=0 at an edge; then go to RDWAIT.
  - RDWAIT: on DOUT_READY, capture data, set ready (or update the MCR cache), go to IDLE.
- Pending requests are not serviced twice: a client holding its acknowledge is excluded from arbitration.
- DOUT_READY arriving outside RDWAIT is ignored.

## Timing
- Reset (async): state IDLE; all ready/done/RD/WE = 0; data outputs 0; MCR cache invalid; BE = 0; ADDR/DIN = 0.
- First action after reset release: an MCR fetch of the current mcr_addr.
- Write latency with BUSY=0: request seen at edge 0, WE high cycle 1 and accepted at edge 2, done high from edge 2.
- Read latency with BUSY=0: RD high cycle 1, accepted at edge 2. DOUT_READY at edge n gives ready high from edge n+1.
- BUSY stalls hold ADDR/DIN/BE/RD/WE constant.
- Reset mid-transaction: the transaction is abandoned and no acknowledge is produced. The bridge is reset together with this block.

## Test plan
- vram_cpu writes 100←0o12345670, 102←0o22222222, 104←0o33333333 -> each done; DDRAM_ADDR = DDR_BASE+0x40_0064 etc.; BE = 0x0F.
- vram_cpu reads 100/102/104 -> data 0o12345670/0o22222222/0o33333333; ready clears after req drops.
- vram_vga reads 100/102/104 -> same values as the CPU-side reads.
- sdram writes 0←0, 1←0o10101111, 2←0o20202222, 4←0o30303333, then read back -> identical data, 4 does not alias 2.
- MCR write 0←49'o111100001111, set mcr_addr=0 -> mcr_ready goes high with that value. Change addr to 1 -> ready drops, a refetch follows.
- Hold DDRAM_BUSY=1 for 5 cycles during a write, plus simultaneous vga and cpu requests -> command held stable, vga serviced first, no lost or duplicate acknowledge.
